// File: rtl/serv_wb_dshot.sv
// Four-channel DShot encoder on the SERV external Wishbone bus; frames are CRC'd and sent in lockstep.
// Define DSHOT_AUTO_REPEAT_EN to add the PERIOD register and its free-running retrigger counter.
module serv_wb_dshot #(
  parameter int BIT_CYCLES = 160,
  parameter int T1H_CYCLES = 120,
  parameter int T0H_CYCLES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [3:0]  o_dshot
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [3:0][11:0]  ch_q, ch_d;
  logic [3:0][15:0]  shift_q, shift_d;
  logic [15:0]       frames_q, frames_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdt_q, rdt_d;
  logic [3:0]        dshot_q, dshot_d;

  logic              req, wr_en, sw_start, auto_start, start;
  logic [2:0]        adr;
  logic [31:0]       rd_mux;
  logic [23:0]       period_rd;
  logic              unused_ok;

  // Handshake: a request (stb & cyc) is acked exactly one cycle later for one cycle;
  // read data is registered into that ack cycle and writes commit at the edge closing it.
  assign req      = i_wb_stb & i_wb_cyc;
  assign adr      = i_wb_adr[4:2];
  assign wr_en    = req & i_wb_we & ack_q;
  assign sw_start = wr_en & (adr == 3'd4) & i_wb_sel[0] & i_wb_dat[0];
  assign start    = sw_start | auto_start;
  assign unused_ok = ^{i_wb_adr[31:5], i_wb_adr[1:0], i_wb_dat[31:12], i_wb_sel[3:2]};

  function automatic logic [15:0] dshot_frame(input logic [11:0] r);
    logic [11:0] v;
    v = {r[10:0], r[11]};
    return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
  endfunction

`ifdef DSHOT_AUTO_REPEAT_EN
  logic [23:0] period_q, period_d, rep_cnt_q, rep_cnt_d;
  logic        pend_q, pend_d, tick, period_wr;

  assign period_wr = wr_en & (adr == 3'd6);
  assign period_rd = period_q;

  always_comb begin
    period_d   = period_q;
    rep_cnt_d  = rep_cnt_q;
    pend_d     = pend_q;
    tick       = 1'b0;
    auto_start = 1'b0;
    if (period_wr) begin
      if (i_wb_sel[0]) period_d[7:0]   = i_wb_dat[7:0];
      if (i_wb_sel[1]) period_d[15:8]  = i_wb_dat[15:8];
      if (i_wb_sel[2]) period_d[23:16] = i_wb_dat[23:16];
    end
    if (period_q != 24'd0) tick = (rep_cnt_q == period_q - 24'd1);
    auto_start = (state_q == ST_IDLE) & (pend_q | tick);
    if (period_wr || period_q == 24'd0 || tick) rep_cnt_d = 24'd0;
    else                                         rep_cnt_d = rep_cnt_q + 24'd1;
    // A wrap during SEND is remembered and launched in the first IDLE cycle.
    if (auto_start)   pend_d = 1'b0;
    else if (tick)    pend_d = 1'b1;
    if (period_d == 24'd0) pend_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_q  <= 24'd0;
      rep_cnt_q <= 24'd0;
      pend_q    <= 1'b0;
    end else begin
      period_q  <= period_d;
      rep_cnt_q <= rep_cnt_d;
      pend_q    <= pend_d;
    end
  end
`else
  assign auto_start = 1'b0;
  assign period_rd  = 24'd0;
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (adr)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = {20'd0, ch_q[adr[1:0]]};
      3'd4:                   rd_mux = {31'd0, state_q == ST_SEND};
      3'd5:                   rd_mux = {16'd0, frames_q};
      3'd6:                   rd_mux = {8'd0, period_rd};
      default:                rd_mux = 32'd0;
    endcase
    ack_d = req & ~ack_q;
    rdt_d = (req & ~ack_q) ? rd_mux : 32'd0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    frames_d = frames_q;
    ch_d     = ch_q;
    dshot_d  = 4'd0;

    for (int i = 0; i < 4; i++) begin
      if (wr_en && !adr[2] && adr[1:0] == 2'(i)) begin
        if (i_wb_sel[0]) ch_d[i][7:0]  = i_wb_dat[7:0];
        if (i_wb_sel[1]) ch_d[i][11:8] = i_wb_dat[11:8];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < 4; i++) shift_d[i] = dshot_frame(ch_q[i]);
          cnt_d   = '0;
          bit_d   = 4'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < 4; i++) shift_d[i] = {shift_q[i][14:0], 1'b0};
          if (bit_q == 4'd15) begin
            frames_d = frames_q + 16'd1;
            state_d  = ST_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered from next-state values so they are glitch-free yet track SEND exactly.
    for (int i = 0; i < 4; i++)
      dshot_d[i] = (state_d == ST_SEND) && (cnt_d < (shift_d[i][15] ? T1H : T0H));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      ch_q     <= '0;
      shift_q  <= '0;
      frames_q <= 16'd0;
      ack_q    <= 1'b0;
      rdt_q    <= 32'd0;
      dshot_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      ch_q     <= ch_d;
      shift_q  <= shift_d;
      frames_q <= frames_d;
      ack_q    <= ack_d;
      rdt_q    <= rdt_d;
      dshot_q  <= dshot_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_dshot  = dshot_q;

endmodule
